mc_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS-lite core. It decodes the latched instruction and sequences fetch, decode, execute, memory and writeback. It drives the `npc` select (`PCsrc`) together with a single per-instruction `PCWr` strobe, and produces every write enable and mux select in the datapath. It sits between the instruction register and the datapath muxes, and it waits on ready handshakes from instruction and data memory.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/mc_decode.sv | 28 ++
 rtl/mc_ctrl.sv | 140 ++++++++++++++
 tb/tb_mc_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller, npc and datapath muxes.
package mips_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DEC   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_R_ALU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILL
  } iclass_t;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BEQ = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct to the class the controller FSM sequences on.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output iclass_t    o_cls
);

  always_comb begin
    o_cls = C_ILL;
    case (i_op)
      OP_R: begin
        if (i_funct == FN_ADDU || i_funct == FN_SUBU) o_cls = C_R_ALU;
        else if (i_funct == FN_JR)                    o_cls = C_JR;
      end
      OP_ORI:  o_cls = C_ORI;
      OP_LUI:  o_cls = C_LUI;
      OP_LW:   o_cls = C_LW;
      OP_SW:   o_cls = C_SW;
      OP_BEQ:  o_cls = C_BEQ;
      OP_J:    o_cls = C_J;
      OP_JAL:  o_cls = C_JAL;
      default: o_cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback, one PC write per instruction.
// state   | meaning
// S_FETCH | wait for imem_rdy, load IR
// S_DEC   | resolve j/jal/jr/illegal, else go execute
// S_EXE   | drive ALU selects; beq completes here
// S_MEM   | data access for lw/sw, wait for dmem_rdy
// S_WB    | register write and PC update
module mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       imem_rdy,
  input  logic       dmem_rdy,
  output logic       IRWr,
  output logic       PCWr,
  output logic [1:0] PCsrc,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ExtOp,
  output logic       MemWr,
  output logic       mem_req,
  output logic       instr_done,
  output logic       illegal
);

  state_t  r_state;
  state_t  w_next;
  iclass_t w_cls;
  logic       w_alusrc;
  logic [1:0] w_aluop;
  logic [1:0] w_extop;

  mc_decode u_decode (
    .i_op    (op),
    .i_funct (funct),
    .o_cls   (w_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // ALU selects depend only on the instruction, so they stay stable from S_EXE through S_WB.
  always_comb begin
    w_alusrc = 1'b0;
    w_aluop  = ALU_ADD;
    w_extop  = EXT_ZERO;
    case (w_cls)
      C_R_ALU: w_aluop = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
      C_ORI:   begin w_alusrc = 1'b1; w_aluop = ALU_OR;    w_extop = EXT_ZERO;  end
      C_LUI:   begin w_alusrc = 1'b1; w_aluop = ALU_PASSB; w_extop = EXT_UPPER; end
      C_LW,
      C_SW:    begin w_alusrc = 1'b1; w_aluop = ALU_ADD;   w_extop = EXT_SIGN;  end
      C_BEQ:   w_aluop = ALU_SUB;
      default: w_alusrc = 1'b0;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    PCsrc    = PCSRC_PC4;
    RegWr    = 1'b0;
    RegDst   = REGDST_RT;
    MemtoReg = MTR_ALU;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    ExtOp    = EXT_ZERO;
    MemWr    = 1'b0;
    mem_req  = 1'b0;
    illegal  = 1'b0;
    // Outputs are gated by rst_n so a reset mid-access drops every strobe immediately.
    if (rst_n) begin
      if (r_state == S_EXE || r_state == S_MEM || r_state == S_WB) begin
        ALUSrc = w_alusrc;
        ALUOp  = w_aluop;
        ExtOp  = w_extop;
      end
      case (r_state)
        S_FETCH: begin
          if (imem_rdy) begin
            IRWr   = 1'b1;
            w_next = S_DEC;
          end
        end
        S_DEC: begin
          w_next = S_FETCH;
          case (w_cls)
            C_J:   begin PCWr = 1'b1; PCsrc = PCSRC_J; end
            C_JAL: begin
              PCWr = 1'b1; PCsrc = PCSRC_J;
              RegWr = 1'b1; RegDst = REGDST_R31; MemtoReg = MTR_PC4;
            end
            C_JR:    begin PCWr = 1'b1; PCsrc = PCSRC_JR; end
            C_ILL:   begin PCWr = 1'b1; illegal = 1'b1; end
            default: w_next = S_EXE;
          endcase
        end
        S_EXE: begin
          case (w_cls)
            C_BEQ:       begin PCWr = 1'b1; PCsrc = PCSRC_BEQ; w_next = S_FETCH; end
            C_LW, C_SW:  w_next = S_MEM;
            default:     w_next = S_WB;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          MemWr   = (w_cls == C_SW);
          if (dmem_rdy) begin
            if (w_cls == C_SW) begin
              PCWr   = 1'b1;
              w_next = S_FETCH;
            end else begin
              w_next = S_WB;
            end
          end
        end
        S_WB: begin
          RegWr    = 1'b1;
          PCWr     = 1'b1;
          RegDst   = (w_cls == C_R_ALU) ? REGDST_RD : REGDST_RT;
          MemtoReg = (w_cls == C_LW) ? MTR_MEM : MTR_ALU;
          w_next   = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

  assign instr_done = PCWr;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected cycle lists checked every cycle, plus hand-computed pins.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       imem_rdy = 1'b0;
  logic       dmem_rdy = 1'b0;
  logic       IRWr, PCWr, RegWr, ALUSrc, MemWr, mem_req, instr_done, illegal;
  logic [1:0] PCsrc, RegDst, MemtoReg, ALUOp, ExtOp;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .imem_rdy   (imem_rdy),
    .dmem_rdy   (dmem_rdy),
    .IRWr       (IRWr),
    .PCWr       (PCWr),
    .PCsrc      (PCsrc),
    .RegWr      (RegWr),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrc     (ALUSrc),
    .ALUOp      (ALUOp),
    .ExtOp      (ExtOp),
    .MemWr      (MemWr),
    .mem_req    (mem_req),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic       irwr;
    logic       pcwr;
    logic [1:0] pcsrc;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] mtr;
    logic       alusrc;
    logic [1:0] aluop;
    logic [1:0] extop;
    logic       memwr;
    logic       memreq;
    logic       done;
    logic       ill;
  } out_t;

  typedef struct {
    logic im;
    logic dm;
    out_t o;
  } step_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } lit_t;

  out_t act;
  assign act = {IRWr, PCWr, PCsrc, RegWr, RegDst, MemtoReg, ALUSrc, ALUOp, ExtOp,
                MemWr, mem_req, instr_done, illegal};

  out_t  exp_q[$];
  lit_t  lit_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    gcyc = 0;
  int    pcwr_cyc[$];
  int    regwr_tot = 0;
  int    memwr_tot = 0;
  int    ill_tot = 0;
  out_t  last_pcwr_vec = '0;

  // Single checker: per-cycle model comparison plus queued literal pins.
  initial begin
    out_t e;
    lit_t l;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        gcyc++;
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL cycle_outputs @%0d: got %b required %b", gcyc, act, e);
        end
        if (act.pcwr) begin
          pcwr_cyc.push_back(gcyc);
          last_pcwr_vec = act;
        end
        if (act.regwr) regwr_tot++;
        if (act.memwr) memwr_tot++;
        if (act.ill)   ill_tot++;
      end
      while (lit_q.size() > 0) begin
        l = lit_q.pop_front();
        n_cmp++;
        if (l.act != l.exp) begin
          n_bad++;
          $display("FAIL %s: got %0h required %0h", l.name, l.act, l.exp);
        end
      end
    end
  end

  localparam int K_ALU = 0, K_ORI = 1, K_LUI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                 K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

  step_t plan[$];
  int    npush = 0;
  int    start_idx = 0;

  task automatic lit(input string n, input int a, input int e);
    lit_t l;
    l.name = n; l.act = a; l.exp = e;
    lit_q.push_back(l);
  endtask

  task automatic add(input logic im, input logic dm, input out_t o);
    step_t s;
    s.im = im; s.dm = dm; s.o = o; s.o.done = o.pcwr;
    plan.push_back(s);
  endtask

  task automatic step(input logic [5:0] iop, input logic [5:0] ifn, input step_t s);
    @(posedge clk);
    #1;
    op = iop; funct = ifn; imem_rdy = s.im; dmem_rdy = s.dm;
    exp_q.push_back(s.o);
    npush++;
  endtask

  // Expected behaviour: the instruction's cycle list from its class and the ready wait counts.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                           input int iw, input int dw, input int abort_after);
    int   k;
    out_t o;
    plan.delete();
    case (iop)
      6'b000000: k = (ifn == 6'b100001 || ifn == 6'b100011) ? K_ALU :
                     (ifn == 6'b001000) ? K_JR : K_ILL;
      6'b001101: k = K_ORI;
      6'b001111: k = K_LUI;
      6'b100011: k = K_LW;
      6'b101011: k = K_SW;
      6'b000100: k = K_BEQ;
      6'b000010: k = K_J;
      6'b000011: k = K_JAL;
      default:   k = K_ILL;
    endcase
    for (int i = 0; i < iw; i++) add(1'b0, 1'b1, '0);
    o = '0; o.irwr = 1'b1;
    add(1'b1, 1'b1, o);
    o = '0;
    if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) begin
      o.pcwr = 1'b1;
      if (k == K_J)  o.pcsrc = 2'b10;
      if (k == K_JR) o.pcsrc = 2'b11;
      if (k == K_ILL) o.ill = 1'b1;
      if (k == K_JAL) begin o.pcsrc = 2'b10; o.regwr = 1'b1; o.regdst = 2'b10; o.mtr = 2'b10; end
      add(1'b1, 1'b1, o);
    end else begin
      add(1'b1, 1'b1, '0);
      o.alusrc = !(k == K_ALU || k == K_BEQ);
      o.aluop  = (k == K_ORI) ? 2'b10 : (k == K_LUI) ? 2'b11 :
                 (k == K_BEQ || (k == K_ALU && ifn == 6'b100011)) ? 2'b01 : 2'b00;
      o.extop  = (k == K_LUI) ? 2'b10 : (k == K_LW || k == K_SW) ? 2'b01 : 2'b00;
      if (k == K_BEQ) begin
        o.pcwr = 1'b1; o.pcsrc = 2'b01;
        add(1'b1, 1'b1, o);
      end else begin
        add(1'b1, 1'b1, o);
        if (k == K_LW || k == K_SW) begin
          o.memreq = 1'b1;
          o.memwr  = (k == K_SW);
          for (int i = 0; i < dw; i++) add(1'b1, 1'b0, o);
          o.pcwr = (k == K_SW);
          add(1'b1, 1'b1, o);
          o.memreq = 1'b0; o.memwr = 1'b0; o.pcwr = 1'b0;
        end
        if (k != K_SW) begin
          o.regwr = 1'b1; o.pcwr = 1'b1;
          o.regdst = (k == K_ALU) ? 2'b01 : 2'b00;
          o.mtr    = (k == K_LW) ? 2'b01 : 2'b00;
          add(1'b1, 1'b1, o);
        end
      end
    end
    start_idx = npush;
    for (int i = 0; i < plan.size(); i++) begin
      if (abort_after > 0 && i == abort_after) break;
      step(iop, ifn, plan[i]);
    end
    if (abort_after > 0) begin
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      lit("reset_abort_zero", 32'(act), 0);
      imem_rdy = 1'b0;
      dmem_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() > 0 || lit_q.size() > 0); i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0 || lit_q.size() > 0) begin
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size() + lit_q.size());
      $fatal(1, "checker stalled");
    end
  endtask

  function automatic int last_rel(input int back);
    if (pcwr_cyc.size() < back) return -1;
    return pcwr_cyc[pcwr_cyc.size() - back] - start_idx;
  endfunction

  initial begin
    int s0, rw0, mw0, il0, np0;
    imem_rdy = 1'b1; dmem_rdy = 1'b1; op = 6'b100011;
    #3;
    lit("reset_outputs", 32'(act), 0);
    #4;
    imem_rdy = 1'b0;
    #10;
    rst_n = 1'b1;

    // addu aborted in S_EXE, then recovery
    run_instr(6'b000000, 6'b100001, 0, 0, 3);

    // addu then lw back to back
    run_instr(6'b000000, 6'b100001, 0, 0, 0);
    s0 = start_idx;
    run_instr(6'b100011, 6'b000000, 0, 0, 0);
    drain();
    lit("addu_pcwr_cycle", pcwr_cyc[pcwr_cyc.size() - 2] - s0, 4);
    lit("lw_pcwr_cycle", pcwr_cyc[pcwr_cyc.size() - 1] - s0, 9);
    lit("lw_wb_vector", 32'(last_pcwr_vec), 32'(18'b0_1_00_1_00_01_1_00_01_0_0_1_0));

    // beq
    rw0 = regwr_tot; mw0 = memwr_tot;
    run_instr(6'b000100, 6'b000000, 0, 0, 0);
    drain();
    lit("beq_pcwr_cycle", last_rel(1), 3);
    lit("beq_vector", 32'(last_pcwr_vec), 32'(18'b0_1_01_0_00_00_0_01_00_0_0_1_0));
    lit("beq_no_regwr", regwr_tot - rw0, 0);
    lit("beq_no_memwr", memwr_tot - mw0, 0);

    // jal
    run_instr(6'b000011, 6'b000000, 0, 0, 0);
    drain();
    lit("jal_pcwr_cycle", last_rel(1), 2);
    lit("jal_vector", 32'(last_pcwr_vec), 32'(18'b0_1_10_1_10_10_0_00_00_0_0_1_0));

    // sw with a 3-cycle dmem stall
    mw0 = memwr_tot; np0 = pcwr_cyc.size();
    run_instr(6'b101011, 6'b000000, 0, 3, 0);
    drain();
    lit("sw_memwr_cycles", memwr_tot - mw0, 4);
    lit("sw_pcwr_count", pcwr_cyc.size() - np0, 1);
    lit("sw_pcwr_cycle", last_rel(1), 7);
    lit("sw_vector", 32'(last_pcwr_vec), 32'(18'b0_1_00_0_00_00_1_00_01_1_1_1_0));

    // undefined opcode
    rw0 = regwr_tot; mw0 = memwr_tot; il0 = ill_tot;
    run_instr(6'b111111, 6'b000000, 0, 0, 0);
    drain();
    lit("ill_pcwr_cycle", last_rel(1), 2);
    lit("ill_vector", 32'(last_pcwr_vec), 32'(18'b0_1_00_0_00_00_0_00_00_0_0_1_1));
    lit("ill_pulse_count", ill_tot - il0, 1);
    lit("ill_no_writes", (regwr_tot - rw0) + (memwr_tot - mw0), 0);

    // remaining classes, fetch stalls, undefined funct
    run_instr(6'b001101, 6'b000000, 2, 0, 0);
    run_instr(6'b001111, 6'b000000, 0, 0, 0);
    run_instr(6'b000000, 6'b100011, 1, 0, 0);
    run_instr(6'b000000, 6'b001000, 0, 0, 0);
    run_instr(6'b000010, 6'b000000, 0, 0, 0);
    run_instr(6'b000000, 6'b000000, 0, 0, 0);
    run_instr(6'b100011, 6'b000000, 1, 2, 0);
    drain();
    lit("lw_stalled_pcwr_cycle", last_rel(1), 8);

    // sw aborted while stalled in S_MEM, then lw recovers
    run_instr(6'b101011, 6'b000000, 0, 2, 4);
    run_instr(6'b100011, 6'b000000, 0, 0, 0);
    drain();
    lit("lw_after_abort_cycle", last_rel(1), 5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
